lock_range_sweep: RTL and testbench

LOCK_RANGE_SWEEP -- requirements
Module: lock_range_sweep

---
 rtl/lock_range_sweep_pkg.sv | 15 +
 rtl/lock_window_check.sv | 54 +++++
 rtl/lock_range_sweep.sv | 144 ++++++++++++++
 tb/tb_lock_range_sweep.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_range_sweep_pkg.sv
// rtl/lock_range_sweep_pkg.sv - shared FSM states and error/magnitude widths for the lock-range sweep
package lock_range_sweep_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        STEP    = 3'd3,
        DONE    = 3'd4
    } sweep_state_t;

    localparam int ERR_WIDTH = 8;
    localparam int MAG_WIDTH = 9;

endpackage

// File: rtl/lock_window_check.sv
// rtl/lock_window_check.sv - |error| window compare with sticky fail flag; peak tracker under LOCK_RANGE_SWEEP_PEAK_EN
module lock_window_check
    import lock_range_sweep_pkg::*;
#(
    parameter int ERR_WINDOW = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 sample,
    input  logic [ERR_WIDTH-1:0] error,
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
    input  logic                 commit,
    output logic [MAG_WIDTH-1:0] peak,
`endif
    output logic                 fail
);

    logic [MAG_WIDTH-1:0] ext;
    logic [MAG_WIDTH-1:0] mag;

    // Sign-extend to 9 bits first so that -128 maps to +128 instead of overflowing.
    always_comb begin
        ext = {error[ERR_WIDTH-1], error};
        mag = ext[MAG_WIDTH-1] ? (~ext + MAG_WIDTH'(1)) : ext;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            fail <= 1'b0;
        end else if (sample && (mag > MAG_WIDTH'(ERR_WINDOW))) begin
            fail <= 1'b1;
        end
    end

`ifdef LOCK_RANGE_SWEEP_PEAK_EN
    logic [MAG_WIDTH-1:0] run_max;

    // commit and clear coincide in STEP, so peak captures run_max before it is wiped.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            run_max <= '0;
        end else if (sample && (mag > run_max)) begin
            run_max <= mag;
        end
        if (reset) begin
            peak <= '0;
        end else if (commit) begin
            peak <= run_max;
        end
    end
`endif

endmodule

// File: rtl/lock_range_sweep.sv
// rtl/lock_range_sweep.sv - ADPLL lock-range sweep FSM; optional peak_err_o with LOCK_RANGE_SWEEP_PEAK_EN
module lock_range_sweep
    import lock_range_sweep_pkg::*;
#(
    parameter int WIDTH          = 12,
    parameter int SETTLE_SAMPLES = 256,
    parameter int DWELL_SAMPLES  = 64,
    parameter int ERR_WINDOW     = 4
) (
    input  logic                 fpga_clk_i,
    input  logic                 reset_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     k_start_i,
    input  logic [WIDTH-1:0]     k_stop_i,
    input  logic                 sample_i,
    input  logic [ERR_WIDTH-1:0] error_i,
    output logic [WIDTH-1:0]     k_val_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 step_lock_o,
    output logic                 found_o,
    output logic [WIDTH-1:0]     k_min_o,
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
    output logic [MAG_WIDTH-1:0] peak_err_o,
`endif
    output logic [WIDTH-1:0]     k_max_o
);

    localparam int SCW = $clog2(SETTLE_SAMPLES + 1);
    localparam int DCW = $clog2(DWELL_SAMPLES + 1);

    sweep_state_t   state;
    logic [SCW-1:0] settle_cnt;
    logic [DCW-1:0] dwell_cnt;
    logic [WIDTH-1:0] k_stop;
    logic           start_ok;
    logic           win_clear;
    logic           win_sample;
    logic           win_fail;

    always_comb begin
        start_ok   = start_i && ((state == IDLE) || (state == DONE));
        win_clear  = start_ok || (state == STEP);
        win_sample = sample_i && (state == MEASURE);
    end

    lock_window_check #(
        .ERR_WINDOW (ERR_WINDOW)
    ) u_window (
        .clk    (fpga_clk_i),
        .reset  (reset_i),
        .clear  (win_clear),
        .sample (win_sample),
        .error  (error_i),
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
        .commit (state == STEP),
        .peak   (peak_err_o),
`endif
        .fail   (win_fail)
    );

    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            state       <= IDLE;
            settle_cnt  <= '0;
            dwell_cnt   <= '0;
            k_stop      <= '0;
            k_val_o     <= '0;
            k_min_o     <= '0;
            k_max_o     <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            step_lock_o <= 1'b0;
            found_o     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_i) begin
                        k_val_o     <= k_start_i;
                        k_stop      <= k_stop_i;
                        found_o     <= 1'b0;
                        step_lock_o <= 1'b0;
                        settle_cnt  <= '0;
                        dwell_cnt   <= '0;
                        if (k_stop_i < k_start_i) begin
                            state  <= DONE;
                            busy_o <= 1'b0;
                            done_o <= 1'b1;
                        end else begin
                            state  <= SETTLE;
                            busy_o <= 1'b1;
                            done_o <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (sample_i) begin
                        if (settle_cnt == SCW'(SETTLE_SAMPLES - 1)) begin
                            state <= MEASURE;
                        end else begin
                            settle_cnt <= settle_cnt + SCW'(1);
                        end
                    end
                end
                MEASURE: begin
                    if (sample_i) begin
                        if (dwell_cnt == DCW'(DWELL_SAMPLES - 1)) begin
                            state <= STEP;
                        end else begin
                            dwell_cnt <= dwell_cnt + DCW'(1);
                        end
                    end
                end
                STEP: begin
                    step_lock_o <= ~win_fail;
                    if (!win_fail) begin
                        k_max_o <= k_val_o;
                        if (!found_o) begin
                            k_min_o <= k_val_o;
                            found_o <= 1'b1;
                        end
                    end
                    // Compare before incrementing so k_stop at the top code never wraps.
                    if (k_val_o == k_stop) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        k_val_o    <= k_val_o + WIDTH'(1);
                        settle_cnt <= '0;
                        dwell_cnt  <= '0;
                        state      <= SETTLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lock_range_sweep.sv
// tb/tb_lock_range_sweep.sv - randomized directed bench for lock_range_sweep against a step-level reference model
module tb_lock_range_sweep;

    localparam int W      = 12;
    localparam int SETTLE = 4;
    localparam int DWELL  = 4;
    localparam int WIN    = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] k_start = '0;
    logic [W-1:0] k_stop = '0;
    logic         sample = 1'b0;
    logic [7:0]   error = '0;
    logic [W-1:0] k_val;
    logic         busy;
    logic         done;
    logic         step_lock;
    logic         found;
    logic [W-1:0] k_min;
    logic [W-1:0] k_max;
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
    logic [8:0]   peak_err;
`endif

    int checks = 0;
    int failures = 0;

    int m_kmin = 0;
    int m_kmax = 0;
    bit m_found = 1'b0;

    always #5 clk = ~clk;

    lock_range_sweep #(
        .WIDTH          (W),
        .SETTLE_SAMPLES (SETTLE),
        .DWELL_SAMPLES  (DWELL),
        .ERR_WINDOW     (WIN)
    ) dut (
        .fpga_clk_i  (clk),
        .reset_i     (reset),
        .start_i     (start),
        .k_start_i   (k_start),
        .k_stop_i    (k_stop),
        .sample_i    (sample),
        .error_i     (error),
        .k_val_o     (k_val),
        .busy_o      (busy),
        .done_o      (done),
        .step_lock_o (step_lock),
        .found_o     (found),
        .k_min_o     (k_min),
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
        .peak_err_o  (peak_err),
`endif
        .k_max_o     (k_max)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int abs8(input logic [7:0] e);
        int v;
        v = int'($signed(e));
        return (v < 0) ? -v : v;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; leaves the strobe high for exactly one rising edge.
    task automatic pulse(input logic [7:0] e);
        sample = 1'b1;
        error  = e;
        @(negedge clk);
        sample = 1'b0;
        error  = 8'($urandom);
    endtask

    task automatic do_start(input int ks, input int ke);
        start   = 1'b1;
        k_start = W'(ks);
        k_stop  = W'(ke);
        @(negedge clk);
        start   = 1'b0;
        k_start = W'($urandom);
        k_stop  = W'($urandom);
    endtask

    task automatic check_idle_reset(input string tag);
        check({tag, "_kval"}, 32'(k_val), 0);
        check({tag, "_kmin"}, 32'(k_min), 0);
        check({tag, "_kmax"}, 32'(k_max), 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_lock"}, 32'(step_lock), 0);
        check({tag, "_found"}, 32'(found), 0);
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
        check({tag, "_peak"}, 32'(peak_err), 0);
`endif
    endtask

    // mode 0: all zero; 1: lock only in 73..77 (else 20); 2: -128 once at k=75; 3: random
    function automatic logic [7:0] gen_err(input int mode, input int k, input int idx,
                                           input bit bad, input int badidx);
        logic [7:0] e;
        if (idx < SETTLE && mode != 0) return 8'($urandom);
        case (mode)
            1: e = (k >= 73 && k <= 77) ? 8'd0 : 8'd20;
            2: e = (k == 75 && idx == SETTLE + 1) ? 8'h80 : 8'd0;
            3: begin
                if (bad && idx == badidx) begin
                    case ($urandom_range(0, 3))
                        0: e = 8'd5;
                        1: e = 8'hFB;
                        2: e = 8'h80;
                        default: e = 8'($urandom_range(5, 127));
                    endcase
                end else begin
                    e = 8'($signed($urandom_range(0, 8)) - 4);
                end
            end
            default: e = 8'd0;
        endcase
        return e;
    endfunction

    task automatic sweep(input string tag, input int ks, input int ke, input int mode);
        logic [7:0] e;
        bit locked;
        bit bad;
        int badidx;
        int peak;
        do_start(ks, ke);
        m_found = 1'b0;
        check({tag, "_start_kval"}, 32'(k_val), 32'(ks));
        check({tag, "_start_found"}, 32'(found), 0);
        if (ke < ks) begin
            check({tag, "_rev_done"}, 32'(done), 1);
            check({tag, "_rev_busy"}, 32'(busy), 0);
            check({tag, "_rev_kmin"}, 32'(k_min), 32'(m_kmin));
            check({tag, "_rev_kmax"}, 32'(k_max), 32'(m_kmax));
            return;
        end
        check({tag, "_start_busy"}, 32'(busy), 1);
        for (int k = ks; k <= ke; k++) begin
            locked = 1'b1;
            peak   = 0;
            bad    = ($urandom_range(0, 2) == 0);
            badidx = SETTLE + int'($urandom_range(0, DWELL - 1));
            for (int idx = 0; idx < SETTLE + DWELL; idx++) begin
                e = gen_err(mode, k, idx, bad, badidx);
                if (idx >= SETTLE) begin
                    if (abs8(e) > WIN) locked = 1'b0;
                    if (abs8(e) > peak) peak = abs8(e);
                end
                if ($urandom_range(0, 2) == 0) idle(1);
                pulse(e);
            end
            // This cycle is the one-cycle step; a strobe here must be dropped.
            if ($urandom_range(0, 1) == 1) pulse(8'd100);
            else idle(1);
            if (locked) begin
                if (!m_found) m_kmin = k;
                m_kmax  = k;
                m_found = 1'b1;
            end
            check($sformatf("%s_lock_k%0d", tag, k), 32'(step_lock), 32'(locked));
            check($sformatf("%s_kval_k%0d", tag, k), 32'(k_val), 32'((k == ke) ? k : k + 1));
`ifdef LOCK_RANGE_SWEEP_PEAK_EN
            check($sformatf("%s_peak_k%0d", tag, k), 32'(peak_err), 32'(peak));
`endif
        end
        check({tag, "_done"}, 32'(done), 1);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_found"}, 32'(found), 32'(m_found));
        check({tag, "_kmin"}, 32'(k_min), 32'(m_kmin));
        check({tag, "_kmax"}, 32'(k_max), 32'(m_kmax));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ks;
        idle(2);
        reset = 1'b0;
        check_idle_reset("reset");

        sweep("all_zero", 70, 80, 0);
        sweep("window", 70, 80, 1);
        sweep("neg128", 70, 80, 2);
        sweep("reverse", 10, 5, 0);
        sweep("top", 4095, 4095, 0);
        idle(3);
        check("top_hold_kval", 32'(k_val), 4095);
        check("top_hold_done", 32'(done), 1);

        for (int r = 0; r < 4; r++) begin
            ks = int'($urandom_range(100, 3000));
            sweep($sformatf("rand%0d", r), ks, ks + int'($urandom_range(0, 10)), 3);
        end

        // Reset mid-measure with a competing start: reset must win.
        do_start(10, 20);
        for (int i = 0; i < SETTLE + 2; i++) pulse(8'd0);
        reset = 1'b1;
        start = 1'b1;
        k_start = W'(33);
        k_stop  = W'(44);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        m_kmin = 0;
        m_kmax = 0;
        m_found = 1'b0;
        check_idle_reset("midreset");

        do_start(30, 40);
        pulse(8'd0);
        pulse(8'd0);
        do_start(50, 60);
        check("ignored_start_kval", 32'(k_val), 30);
        check("ignored_start_busy", 32'(busy), 1);
        check("ignored_start_done", 32'(done), 0);

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
